// File: rtl/alu_result_stage.sv
// Two-entry result buffer behind the ALU: stores result, opcode and status flags, and
// delivers them over valid/ready while counting handshakes. Optional macro: ALU_RESULT_FLAGS_EN.
module alu_result_stage #(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic [2:0]       in_aop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [2:0]       out_aop,
  output logic             out_illegal,
  output logic             out_zero,
  output logic             out_neg,
  output logic [CNT_W-1:0] out_count
);

  function automatic logic f_illegal(input logic [2:0] aop);
    return (aop == 3'b010) || (aop == 3'b111);
  endfunction

  logic [N-1:0]     r_data [2];
  logic [2:0]       r_aop  [2];
  logic             r_ill  [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_occ;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  // Handshake decisions depend only on registered occupancy.
  assign in_ready  = (r_occ != 2'd2);
  assign out_valid = (r_occ != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_occ   <= 2'd0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop) begin
        r_rptr  <= ~r_rptr;
        r_count <= r_count + CNT_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Storage is cleared on reset so the head fields read zero while empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_data[i] <= '0;
        r_aop[i]  <= 3'b000;
        r_ill[i]  <= 1'b0;
      end
    end else if (w_push) begin
      r_data[r_wptr] <= in_data;
      r_aop[r_wptr]  <= in_aop;
      r_ill[r_wptr]  <= f_illegal(in_aop);
    end
  end

  assign out_data    = r_data[r_rptr];
  assign out_aop     = r_aop[r_rptr];
  assign out_illegal = r_ill[r_rptr];
  assign out_count   = r_count;

`ifdef ALU_RESULT_FLAGS_EN
  function automatic logic f_zero(input logic [N-1:0] d);
    return (d == '0);
  endfunction

  logic r_zero [2];
  logic r_neg  [2];

  // Flags are captured with the entry, never recomputed from out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_zero[i] <= 1'b0;
        r_neg[i]  <= 1'b0;
      end
    end else if (w_push) begin
      r_zero[r_wptr] <= f_zero(in_data);
      r_neg[r_wptr]  <= in_data[N-1];
    end
  end

  assign out_zero = r_zero[r_rptr];
  assign out_neg  = r_neg[r_rptr];
`else
  assign out_zero = 1'b0;
  assign out_neg  = 1'b0;
`endif

endmodule
